// File: rtl/udp_filter_arb_pkg.sv
// Shared types and constants for the udp_filter front-end arbiter.
package udp_filter_arb_pkg;

  localparam int unsigned IPV4_ADDR_WIDTH = 32;

  // First beat index the filter treats as eligible for frame_last.
  localparam logic [2:0] LAST_BEAT_IDX = 3'd5;

  typedef enum logic [2:0] {
    ARB,
    START,
    STREAM,
    PAD,
    DRAIN
  } arb_state_e;

endpackage

// File: rtl/udp_filter_arbiter_if.sv
// Bundle of the per-port AXI-Stream receive signals and the udp_filter sequencing bus.
interface udp_filter_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PORT_NR    = 4
);
  import udp_filter_arb_pkg::*;

  logic [PORT_NR*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORT_NR-1:0]            s_axis_tvalid;
  logic [PORT_NR-1:0]            s_axis_tlast;
  logic [PORT_NR-1:0]            s_axis_tready;

  logic                          flt_en;
  logic [DATA_WIDTH-1:0]         flt_frame;
  logic                          flt_frame_last;
  logic [IPV4_ADDR_WIDTH-1:0]    flt_ipv4_addr;
  logic                          flt_fifo_rst_n;
  logic                          flt_frame_valid;

  // Arbiter side: consumes upstream beats and drives the filter.
  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  flt_fifo_rst_n, flt_frame_valid,
    output s_axis_tready,
    output flt_en, flt_frame, flt_frame_last, flt_ipv4_addr
  );

  // Environment side: upstream receivers plus the filter.
  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output flt_fifo_rst_n, flt_frame_valid,
    input  s_axis_tready,
    input  flt_en, flt_frame, flt_frame_last, flt_ipv4_addr
  );

endinterface

// File: rtl/udp_filter_arbiter_rr_arbiter.sv
// Combinational one-hot round-robin picker: first requester at or after last+1 (mod PORT_NR).
module rr_arbiter #(
  parameter  int unsigned PORT_NR = 4,
  localparam int unsigned IDX_W   = $clog2(PORT_NR)
) (
  input  logic [PORT_NR-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [PORT_NR-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < PORT_NR; i++) begin
      cand = IDX_W'((32'(last) + i + 32'd1) % PORT_NR);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/udp_filter_arbiter.sv
// Frame-granular round-robin arbiter sharing one udp_filter between PORT_NR AXIS ports;
// sequences start beat, payload, runt padding and waits for the filter to drain.
module udp_filter_arbiter
  import udp_filter_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PORT_NR    = 4
) (
  input  logic                               clk_i,
  input  logic                               a_rst_n_i,
  input  logic                               en_i,
  input  logic [PORT_NR*IPV4_ADDR_WIDTH-1:0] ipv4_addr_i,
  udp_filter_arbiter_if.master               bus,
  output logic [PORT_NR-1:0]                 grant_o,
  output logic                               busy_o,
  output logic                               runt_o
);

  localparam int unsigned IDX_W = $clog2(PORT_NR);

  arb_state_e                 state, state_n;
  logic [PORT_NR-1:0]         grant_n;
  logic [IDX_W-1:0]           gidx, gidx_n;
  logic [IDX_W-1:0]           last_grant, last_grant_n;
  logic [2:0]                 beat_cnt, beat_cnt_n;
  logic [IPV4_ADDR_WIDTH-1:0] addr_q, addr_n;

  logic [PORT_NR-1:0]         pick;
  logic [IDX_W-1:0]           pick_idx;
  logic                       pick_valid;
  logic                       tvalid_g, tlast_g, xfer;

  logic [DATA_WIDTH-1:0]      tdata_arr [PORT_NR];
  logic [IPV4_ADDR_WIDTH-1:0] addr_arr  [PORT_NR];

  for (genvar p = 0; p < PORT_NR; p++) begin : g_unpack
    assign tdata_arr[p] = bus.s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
    assign addr_arr[p]  = ipv4_addr_i[p*IPV4_ADDR_WIDTH +: IPV4_ADDR_WIDTH];
  end

  rr_arbiter #(.PORT_NR(PORT_NR)) u_rr (
    .req     (bus.s_axis_tvalid),
    .last    (last_grant),
    .gnt     (pick),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  assign tvalid_g          = |(bus.s_axis_tvalid & grant_o);
  assign tlast_g           = |(bus.s_axis_tlast & grant_o);
  assign bus.flt_ipv4_addr = addr_q;
  assign busy_o            = (state != ARB);

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state      <= ARB;
      grant_o    <= '0;
      gidx       <= '0;
      last_grant <= IDX_W'(PORT_NR - 1);
      beat_cnt   <= '0;
      addr_q     <= '0;
    end else begin
      state      <= state_n;
      grant_o    <= grant_n;
      gidx       <= gidx_n;
      last_grant <= last_grant_n;
      beat_cnt   <= beat_cnt_n;
      addr_q     <= addr_n;
    end
  end

  always_comb begin
    state_n            = state;
    grant_n            = grant_o;
    gidx_n             = gidx;
    last_grant_n       = last_grant;
    beat_cnt_n         = beat_cnt;
    addr_n             = addr_q;
    xfer               = 1'b0;
    runt_o             = 1'b0;
    bus.s_axis_tready  = '0;
    bus.flt_en         = 1'b0;
    bus.flt_frame      = '0;
    bus.flt_frame_last = 1'b0;

    unique case (state)
      ARB: begin
        if (en_i && pick_valid) begin
          state_n = START;
          grant_n = pick;
          gidx_n  = pick_idx;
          addr_n  = addr_arr[pick_idx];
        end
      end

      START: begin
        bus.flt_en = 1'b1;
        state_n    = STREAM;
      end

      STREAM: begin
        // A low fifo_rst_n holds the beat upstream, so nothing is lost or repeated.
        bus.s_axis_tready  = grant_o & {PORT_NR{bus.flt_fifo_rst_n}};
        xfer               = tvalid_g & bus.flt_fifo_rst_n;
        bus.flt_en         = xfer;
        bus.flt_frame      = tdata_arr[gidx];
        bus.flt_frame_last = tlast_g && (beat_cnt == LAST_BEAT_IDX) && xfer;
        if (xfer) begin
          if (beat_cnt != LAST_BEAT_IDX) beat_cnt_n = 3'(beat_cnt + 3'd1);
          if (tlast_g) begin
            if (beat_cnt == LAST_BEAT_IDX) begin
              state_n = DRAIN;
            end else begin
              state_n = PAD;
              runt_o  = 1'b1;
            end
          end
        end
      end

      PAD: begin
        bus.flt_en = bus.flt_fifo_rst_n;
        if (bus.flt_fifo_rst_n) begin
          if (beat_cnt == LAST_BEAT_IDX) begin
            bus.flt_frame_last = 1'b1;
            state_n            = DRAIN;
          end else begin
            beat_cnt_n = 3'(beat_cnt + 3'd1);
          end
        end
      end

      DRAIN: begin
        if (!bus.flt_frame_valid) begin
          state_n      = ARB;
          last_grant_n = gidx;
          grant_n      = '0;
          beat_cnt_n   = '0;
        end
      end

      default: state_n = ARB;
    endcase
  end

endmodule

// File: tb/tb_udp_filter_arbiter.sv
// Directed bench for udp_filter_arbiter: single frame, round-robin, stall, runt, addresses, async reset.
module tb_udp_filter_arbiter;
  import udp_filter_arb_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned PN = 4;

  localparam logic [31:0] ADDR0 = 32'h0A00_0001;
  localparam logic [31:0] ADDR1 = 32'hC0A8_0102;
  localparam logic [31:0] ADDR2 = 32'hAC10_0203;
  localparam logic [31:0] ADDR3 = 32'h0B0B_0B04;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [PN*32-1:0]  ipv4_addr;
  logic [PN-1:0]     grant;
  logic              busy;
  logic              runt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  udp_filter_arbiter_if #(.DATA_WIDTH(DW), .PORT_NR(PN)) bus ();

  udp_filter_arbiter #(.DATA_WIDTH(DW), .PORT_NR(PN)) dut (
    .clk_i       (clk),
    .a_rst_n_i   (rst_n),
    .en_i        (en),
    .ipv4_addr_i (ipv4_addr),
    .bus         (bus),
    .grant_o     (grant),
    .busy_o      (busy),
    .runt_o      (runt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_val(input int unsigned p, input int unsigned i);
    return 64'hA5A5_0000_0000_0000 | (64'(p) << 16) | 64'(i + 1);
  endfunction

  task automatic set_data(input int unsigned port, input logic [63:0] v);
    bus.s_axis_tdata[port*DW +: DW] = v;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"},  grant, '0);
    chk({tag, "_tready"}, bus.s_axis_tready, '0);
    chk({tag, "_en"},     bus.flt_en, 0);
    chk({tag, "_frame"},  bus.flt_frame, '0);
    chk({tag, "_last"},   bus.flt_frame_last, 0);
    chk({tag, "_runt"},   runt, 0);
    chk({tag, "_addr"},   bus.flt_ipv4_addr, '0);
    chk({tag, "_busy"},   busy, 0);
  endtask

  // Drives one frame from 'port' through START/STREAM/PAD/DRAIN; en is dropped after the grant.
  task automatic run_frame(input int unsigned port, input int unsigned nbeats, input int stall_at,
                           input int unsigned drain, input logic [PN-1:0] others,
                           input logic [31:0] exp_addr);
    logic [PN-1:0] oh;
    int unsigned   i;
    int unsigned   nen;
    bit            stalled;
    oh       = '0;
    oh[port] = 1'b1;
    en = 1'b1;
    bus.s_axis_tvalid = oh | others;
    bus.s_axis_tlast  = '0;
    set_data(port, beat_val(port, 0));
    #1;
    chk("arb_busy", busy, 0);
    chk("arb_tready", bus.s_axis_tready, '0);
    tick();
    en = 1'b0;
    chk("start_grant", grant, oh);
    chk("start_en", bus.flt_en, 1);
    chk("start_frame", bus.flt_frame, '0);
    chk("start_last", bus.flt_frame_last, 0);
    chk("start_tready", bus.s_axis_tready, '0);
    chk("start_addr", bus.flt_ipv4_addr, exp_addr);
    chk("start_busy", busy, 1);
    tick();
    i = 0; nen = 0; stalled = 1'b0;
    while (i < nbeats) begin
      set_data(port, beat_val(port, i));
      bus.s_axis_tlast[port] = (i == nbeats - 1);
      if (int'(i) == stall_at && !stalled) begin
        bus.flt_fifo_rst_n = 1'b0;
        #1;
        chk("stall_tready", bus.s_axis_tready, '0);
        chk("stall_en", bus.flt_en, 0);
        tick();
        bus.flt_fifo_rst_n = 1'b1;
        stalled = 1'b1;
      end else begin
        #1;
        chk("beat_tready", bus.s_axis_tready, oh);
        chk("beat_en", bus.flt_en, 1);
        chk("beat_frame", bus.flt_frame, beat_val(port, i));
        chk("beat_last", bus.flt_frame_last, (i == nbeats - 1) && (i >= 5));
        chk("beat_runt", runt, (i == nbeats - 1) && (i < 5));
        if (bus.flt_en) nen++;
        tick();
        i++;
      end
    end
    bus.s_axis_tvalid = others;
    bus.s_axis_tlast  = '0;
    chk("beat_count", nen, nbeats);
    for (int unsigned k = nbeats; k < 6; k++) begin
      #1;
      chk("pad_en", bus.flt_en, 1);
      chk("pad_frame", bus.flt_frame, '0);
      chk("pad_tready", bus.s_axis_tready, '0);
      chk("pad_last", bus.flt_frame_last, k == 5);
      chk("pad_runt", runt, 0);
      tick();
    end
    bus.flt_frame_valid = 1'b1;
    for (int unsigned d = 0; d < drain; d++) begin
      #1;
      chk("drain_grant", grant, oh);
      chk("drain_en", bus.flt_en, 0);
      chk("drain_busy", busy, 1);
      chk("drain_tready", bus.s_axis_tready, '0);
      tick();
    end
    bus.flt_frame_valid = 1'b0;
    #1;
    chk("drain_exit_busy", busy, 1);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, '0);
  endtask

  initial begin
    rst_n               = 1'b0;
    en                  = 1'b0;
    ipv4_addr           = {ADDR3, ADDR2, ADDR1, ADDR0};
    bus.s_axis_tvalid   = '0;
    bus.s_axis_tlast    = '0;
    bus.flt_fifo_rst_n  = 1'b1;
    bus.flt_frame_valid = 1'b0;
    for (int unsigned p = 0; p < PN; p++) set_data(p, 64'hBAD0_0000_0000_0000 | 64'(p));
    #1;
    chk_idle_outputs("reset");
    #11 rst_n = 1'b1;
    tick();

    // Single 8-beat frame on port 0 with a 3-cycle filter drain.
    run_frame(0, 8, -1, 3, 4'b0000, ADDR0);

    rst_n = 1'b0;
    #2;
    chk_idle_outputs("reset2");
    rst_n = 1'b1;
    tick();

    // Ports 0 and 2 both requesting: grants must alternate 0,2,0,2.
    run_frame(0, 6, -1, 0, 4'b0100, ADDR0);
    run_frame(2, 6, -1, 0, 4'b0001, ADDR2);
    run_frame(0, 6, -1, 0, 4'b0100, ADDR0);
    run_frame(2, 6, -1, 1, 4'b0000, ADDR2);

    // Runt frame on port 1 padded to six beats.
    run_frame(1, 3, -1, 1, 4'b0000, ADDR1);

    // Wrong-frame stall on beat 2 of a 7-beat frame.
    run_frame(0, 7, 2, 2, 4'b0000, ADDR0);

    // Arbitration disabled: a request must not be granted.
    en = 1'b0;
    bus.s_axis_tvalid = 4'b0001;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      chk("dis_busy", busy, 0);
      chk("dis_grant", grant, '0);
    end
    bus.s_axis_tvalid = '0;

    // Async reset in the middle of a port-3 frame.
    en = 1'b1;
    bus.s_axis_tvalid = 4'b1000;
    set_data(3, beat_val(3, 0));
    tick();
    en = 1'b0;
    chk("mid_grant", grant, 4'b1000);
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      set_data(3, beat_val(3, i));
      tick();
    end
    set_data(3, beat_val(3, 4));
    #1;
    chk("mid_tready", bus.s_axis_tready, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    bus.s_axis_tvalid = 4'b1001;
    #1;
    tick();
    chk("post_reset_grant", grant, 4'b0001);
    chk("post_reset_addr", bus.flt_ipv4_addr, ADDR0);
    bus.s_axis_tvalid = '0;
    en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
